// File: rtl/bitmanip_wb_buffer.sv
// Result buffer between the bitmanip unit and the shared writeback port.
// Holds completed results (with transaction ID and exception flag) in an
// in-order FIFO and offers the oldest one to writeback with valid/ready.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              drop everything buffered and anything arriving this cycle
//   in_valid_i/in_ready_o, in_result_i, in_trans_id_i, in_ex_valid_i
//                        result intake from the bitmanip unit
//   wb_valid_o/wb_ready_i, wb_result_o, wb_trans_id_o, wb_ex_valid_o
//                        head entry toward writeback
//   count_o              current occupancy
module bitmanip_wb_buffer #(
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [XLEN-1:0]            in_result_i,
  input  logic [TRANS_ID_BITS-1:0]   in_trans_id_i,
  input  logic                       in_ex_valid_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [XLEN-1:0]            wb_result_o,
  output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic                       wb_ex_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]          result_q [DEPTH];
  logic [TRANS_ID_BITS-1:0] id_q     [DEPTH];
  logic                     ex_q     [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic push;
  logic pop;

  // Handshake qualification; flush suppresses both sides.
  assign in_ready_o = (count_q != CNT_W'(DEPTH));
  assign wb_valid_o = (count_q != CNT_W'(0));
  assign push       = in_valid_i & in_ready_o & ~flush_i;
  assign pop        = wb_valid_o & wb_ready_i & ~flush_i;
  assign count_o    = count_q;

  // Head entry, zeroed when empty so stale storage never leaks out.
  assign wb_result_o   = wb_valid_o ? result_q[rd_ptr_q] : '0;
  assign wb_trans_id_o = wb_valid_o ? id_q[rd_ptr_q]     : '0;
  assign wb_ex_valid_o = wb_valid_o ? ex_q[rd_ptr_q]     : 1'b0;

  // Entry storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        result_q[i] <= '0;
        id_q[i]     <= '0;
        ex_q[i]     <= 1'b0;
      end
    end else if (push) begin
      result_q[wr_ptr_q] <= in_result_i;
      id_q[wr_ptr_q]     <= in_trans_id_i;
      ex_q[wr_ptr_q]     <= in_ex_valid_i;
    end
  end

  // Pointers and occupancy; full/empty are told apart by count, pointers wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Occupancy sanity.
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (count_q == CNT_W'(DEPTH))));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && (count_q == CNT_W'(0))));
  a_count_bound:  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (count_q <= CNT_W'(DEPTH)));

endmodule

// File: tb/tb_bitmanip_wb_buffer.sv
// Bench for bitmanip_wb_buffer: directed steps, with a queue scoreboard that
// receives expected entries at push time and is drained when writeback takes them.
module tb_bitmanip_wb_buffer;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned TIDW  = 3;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_result;
  logic [TIDW-1:0] in_trans_id;
  logic            in_ex;
  logic            wb_valid;
  logic            wb_ready;
  logic [XLEN-1:0] wb_result;
  logic [TIDW-1:0] wb_trans_id;
  logic            wb_ex;
  logic [CW-1:0]   count;

  always #5 clk = ~clk;

  bitmanip_wb_buffer #(.DEPTH(DEPTH), .TRANS_ID_BITS(TIDW), .XLEN(XLEN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_result_i(in_result),
    .in_trans_id_i(in_trans_id), .in_ex_valid_i(in_ex),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_result_o(wb_result),
    .wb_trans_id_o(wb_trans_id), .wb_ex_valid_o(wb_ex), .count_o(count)
  );

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic [TIDW-1:0] id;
    logic            ex;
  } ent_t;

  ent_t mq[$];    // entries the buffer should hold, oldest first
  int   seen[$];  // IDs consumed by writeback, in order
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] r, input int id, input logic ex);
    in_valid    = v;
    in_result   = r;
    in_trans_id = TIDW'(id);
    in_ex       = ex;
  endtask

  // One clock: compare outputs against the scoreboard mid-cycle, then advance it.
  task automatic cycle();
    ent_t h;
    logic pu;
    logic po;
    @(negedge clk);
    chk("wb_valid", 64'(wb_valid), 64'(mq.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
    chk("count",    64'(count),    64'(mq.size()));
    if (mq.size() != 0) begin
      h = mq[0];
      chk("wb_result",   wb_result,         h.res);
      chk("wb_trans_id", 64'(wb_trans_id),  64'(h.id));
      chk("wb_ex_valid", 64'(wb_ex),        64'(h.ex));
    end else begin
      chk("wb_result_empty",   wb_result,        64'd0);
      chk("wb_trans_id_empty", 64'(wb_trans_id), 64'd0);
      chk("wb_ex_valid_empty", 64'(wb_ex),       64'd0);
    end
    pu = in_valid && (mq.size() != DEPTH) && !flush;
    po = (mq.size() != 0) && wb_ready && !flush;
    if (flush) begin
      mq.delete();
    end else begin
      if (po) begin
        h = mq.pop_front();
        seen.push_back(int'(h.id));
      end
      if (pu) begin
        h.res = in_result;
        h.id  = in_trans_id;
        h.ex  = in_ex;
        mq.push_back(h);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    wb_ready = 1'b0;
    drive(1'b0, 64'd0, 0, 1'b0);

    // Reset state.
    #3;
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_count", 64'(count),    64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_result", wb_result,    64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pass-through.
    seen.delete();
    wb_ready = 1'b1;
    drive(1'b1, 64'h40, 3, 1'b0);
    cycle();
    drive(1'b0, 64'd0, 0, 1'b0);
    chk("pt_valid",  64'(wb_valid),    64'd1);
    chk("pt_result", wb_result,        64'h40);
    chk("pt_id",     64'(wb_trans_id), 64'd3);
    chk("pt_ex",     64'(wb_ex),       64'd0);
    cycle();
    chk("pt_drained_valid", 64'(wb_valid), 64'd0);
    chk("pt_drained_count", 64'(count),    64'd0);
    chk("pt_seen_n", 64'(seen.size()), 64'd1);

    // Back-pressure fill.
    seen.delete();
    wb_ready = 1'b0;
    drive(1'b1, 64'h1111, 1, 1'b0);
    cycle();
    drive(1'b1, 64'h2222, 2, 1'b0);
    cycle();
    drive(1'b1, 64'h3333, 3, 1'b1);
    chk("bp_ready_full", 64'(in_ready), 64'd0);
    chk("bp_count_full", 64'(count),    64'd2);
    cycle();
    cycle();
    chk("bp_head_held", 64'(wb_trans_id), 64'd1);
    chk("bp_count_held", 64'(count),      64'd2);
    wb_ready = 1'b1;
    cycle();
    cycle();
    drive(1'b0, 64'd0, 0, 1'b0);
    cycle();
    cycle();
    chk("bp_seen_n", 64'(seen.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk("bp_order", 64'((i < seen.size()) ? seen[i] : -1), 64'(i + 1));

    // Continuous stream with simultaneous push/pop; wraps pointers 4 times.
    seen.delete();
    wb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, {32'hA5A5_0000, 32'($urandom)}, i, 1'(i % 3 == 0));
      cycle();
      chk("st_count", 64'(count), 64'd1);
    end
    drive(1'b0, 64'd0, 0, 1'b0);
    cycle();
    chk("st_seen_n", 64'(seen.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      chk("st_order", 64'((i < seen.size()) ? seen[i] : -1), 64'(i));

    // Flush while full with a concurrent handshake and push.
    seen.delete();
    wb_ready = 1'b0;
    drive(1'b1, 64'h4444, 4, 1'b0);
    cycle();
    drive(1'b1, 64'h5555, 5, 1'b0);
    cycle();
    wb_ready = 1'b1;
    flush    = 1'b1;
    drive(1'b1, 64'h6666, 6, 1'b0);
    cycle();
    flush = 1'b0;
    drive(1'b0, 64'd0, 0, 1'b0);
    chk("fl_count", 64'(count),    64'd0);
    chk("fl_valid", 64'(wb_valid), 64'd0);
    cycle();
    cycle();
    chk("fl_seen_n", 64'(seen.size()), 64'd0);

    // Exception propagation.
    wb_ready = 1'b0;
    drive(1'b1, 64'd0, 2, 1'b1);
    cycle();
    drive(1'b0, 64'd0, 0, 1'b0);
    chk("ex_flag", 64'(wb_ex),       64'd1);
    chk("ex_id",   64'(wb_trans_id), 64'd2);
    wb_ready = 1'b1;
    cycle();
    chk("ex_cleared", 64'(wb_ex),    64'd0);
    chk("ex_valid",   64'(wb_valid), 64'd0);

    // Asynchronous reset mid-operation.
    wb_ready = 1'b0;
    drive(1'b1, 64'h7001, 1, 1'b0);
    cycle();
    drive(1'b1, 64'h7002, 2, 1'b0);
    cycle();
    drive(1'b0, 64'd0, 0, 1'b0);
    chk("ar_count_pre", 64'(count), 64'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(wb_valid), 64'd0);
    chk("ar_count", 64'(count),    64'd0);
    chk("ar_ready", 64'(in_ready), 64'd1);
    chk("ar_result", wb_result,    64'd0);
    mq.delete();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    seen.delete();
    wb_ready = 1'b1;
    drive(1'b1, 64'h7777, 7, 1'b0);
    cycle();
    drive(1'b0, 64'd0, 0, 1'b0);
    cycle();
    chk("ar_seen_n", 64'(seen.size()), 64'd1);
    chk("ar_first_id", 64'((seen.size() > 0) ? seen[0] : -1), 64'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
